// File: rtl/dst40_round_engine.sv
// dst40_round_engine: DST40 round sequencer driving the f-network; optional DST40_ABORT_EN adds an abort input
module dst40_round_engine #(
  parameter int ROUNDS   = 200,
  parameter int RESP_W   = 24,
  parameter int KEY_STEP = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [39:0]       key,
  input  logic [39:0]       challenge,
`ifdef DST40_ABORT_EN
  input  logic              abort,
`endif
  output logic [39:0]       f_key,
  output logic [39:0]       f_chal,
  input  logic [1:0]        f_res,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] response
);
  localparam int RW = $clog2(ROUNDS);
  localparam int SW = KEY_STEP > 1 ? $clog2(KEY_STEP) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic [SW-1:0] scnt;
  logic [39:0] kr, cr, kn, cn;
  logic ab, last, kstep;
`ifdef DST40_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  assign last  = rcnt == RW'(ROUNDS - 1);
  assign kstep = scnt == SW'(KEY_STEP - 1);
  assign cn    = {cr[1:0] ^ f_res, cr[39:2]};
  assign kn    = {kr[0] ^ kr[2] ^ kr[19] ^ kr[21], kr[39:1]};
  assign f_key  = kr;
  assign f_chal = cr;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: abort beats the final round; DONE lasts one cycle and can accept start
  always_comb begin
    nxt = state;
    nxt = state == RUN ? (ab ? IDLE : last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // status outputs decoded from the registered state
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // datapath: load on accept, one round per RUN cycle, capture response on the last round
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kr       <= '0;
      cr       <= '0;
      rcnt     <= '0;
      scnt     <= '0;
      response <= '0;
    end else if (state != RUN) begin
      if (start) begin
        kr   <= key;
        cr   <= challenge;
        rcnt <= '0;
        scnt <= '0;
      end
    end else if (!ab) begin
      cr   <= cn;
      kr   <= kstep ? kn : kr;
      scnt <= kstep ? '0 : scnt + SW'(1);
      rcnt <= rcnt + RW'(1);
      if (last) response <= cn[RESP_W-1:0];
    end
endmodule

// File: tb/tb_dst40_round_engine.sv
// tb_dst40_round_engine: randomized self-checking bench against a round-schedule reference model
module tb_dst40_round_engine;
  localparam int ROUNDS = 200, RESP_W = 24, KEY_STEP = 3;
  logic clk = 0, rst_n = 0, start = 0;
  logic [39:0] key = '0, challenge = '0, f_key, f_chal;
  logic [1:0] f_res, fconst = 2'b00;
  logic fmode = 0;
  logic busy, done;
  logic [RESP_W-1:0] response, last_resp;
  int total = 0, bad = 0;
`ifdef DST40_ABORT_EN
  logic abort = 0;
`endif
  always #5 clk = ~clk;
  function automatic logic [1:0] ffun(logic [39:0] k, logic [39:0] c);
    return {^(k & c), ^(k[39:20] ^ c[19:0])};
  endfunction
  assign f_res = fmode ? ffun(f_key, f_chal) : fconst;
  dst40_round_engine #(.ROUNDS(ROUNDS), .RESP_W(RESP_W), .KEY_STEP(KEY_STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .challenge(challenge),
`ifdef DST40_ABORT_EN
    .abort(abort),
`endif
    .f_key(f_key), .f_chal(f_chal), .f_res(f_res), .busy(busy), .done(done), .response(response));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [RESP_W-1:0] ref_resp(logic [39:0] k, logic [39:0] c);
    logic [1:0] fr;
    for (int r = 1; r <= ROUNDS; r++) begin
      fr = ffun(k, c);
      c = {c[1:0] ^ fr, c[39:2]};
      if (r % KEY_STEP == 0) k = {k[0] ^ k[2] ^ k[19] ^ k[21], k[39:1]};
    end
    return c[RESP_W-1:0];
  endfunction
  function automatic logic [39:0] rnd40();
    logic [63:0] t = {$urandom, $urandom};
    return t[39:0];
  endfunction
  task automatic do_reset();
    #3 rst_n = 0;
    #1 rst_n = 1;
  endtask
  task automatic do_start(input logic [39:0] k, input logic [39:0] c);
    @(negedge clk);
    key = k;
    challenge = c;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(input int pulse_at, output int e, output int bc);
    e = 1;
    bc = 0;
    while (e < 400) begin
      @(negedge clk);
      if (done) break;
      bc += int'(busy);
      start = e == pulse_at;
      if (e == pulse_at) key = ~key;
      @(posedge clk);
      e++;
    end
    start = 0;
    check("latency", e, ROUNDS + 1);
  endtask
  initial begin
    int e, bc, seen;
    logic [39:0] k, c;
    logic [RESP_W-1:0] exp;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", response, 0);
    check("rst_fkey", f_key, 0);
    check("rst_fchal", f_chal, 0);
    rst_n = 1;
    do_start(40'h0, 40'h0);
    wait_done(-1, e, bc);
    check("zero_busy_cycles", bc, ROUNDS);
    check("zero_done", done, 1);
    check("zero_busy_off", busy, 0);
    check("zero_resp", response, 24'h0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    do_start(40'h0, 40'h3);
    @(posedge clk);
    #1 check("chal_f00", f_chal, 40'hC0_0000_0000);
    do_reset();
    fconst = 2'b11;
    do_start(40'h0, 40'h3);
    @(posedge clk);
    #1 check("chal_f11", f_chal, 40'h0);
    do_reset();
    fconst = 2'b00;
    do_start(40'h1, 40'h0);
    for (int r = 1; r <= 6; r++) begin
      @(posedge clk);
      #1;
      if (r < 3) check($sformatf("key_r%0d", r), f_key, 40'h1);
      else if (r < 6) check($sformatf("key_r%0d", r), f_key, 40'h80_0000_0000);
      else check("key_r6", f_key, 40'h40_0000_0000);
    end
    #2 rst_n = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_resp", response, 0);
    check("async_fkey", f_key, 0);
    check("async_fchal", f_chal, 0);
    rst_n = 1;
    fmode = 1;
    for (int i = 0; i < 3; i++) begin
      k = rnd40();
      c = rnd40();
      do_start(k, c);
      wait_done(i == 1 ? 50 : -1, e, bc);
      check($sformatf("rand_resp%0d", i), response, ref_resp(k, c));
      check("rand_done", done, 1);
    end
    k = rnd40();
    c = rnd40();
    key = k;
    challenge = c;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    check("busy_after_done_start", busy, 1);
    wait_done(-1, e, bc);
    exp = ref_resp(k, c);
    check("chain_resp", response, exp);
    last_resp = response;
`ifdef DST40_ABORT_EN
    do_start(rnd40(), rnd40());
    repeat (99) @(posedge clk);
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (205) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("abort_no_done", seen, 0);
    check("abort_resp_kept", response, last_resp);
    k = rnd40();
    c = rnd40();
    do_start(k, c);
    wait_done(-1, e, bc);
    check("post_abort_resp", response, ref_resp(k, c));
`else
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(done | busy);
    end
    check("idle_quiet", seen, 0);
    check("idle_resp_kept", response, last_resp);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
